// File: rtl/bnn_psum_collector_pkg.sv
// Shared constants and the counter-width helper for the BNN partial-sum collector.
package bnn_pkg;

   localparam int PSUM_WIDTH_DEF = 4;
   localparam int ACC_WIDTH_DEF  = 8;
   localparam int PACK_WIDTH_DEF = 8;

   // Smallest r (at least 1) with 2**r >= value.
   function automatic int clog2(input int value);
      int result;
      result = 1;
      for (int i = 1; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            result = i + 1;
         end else begin
            result = result;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/bnn_psum_collector_bit_packer.sv
// Packs binarized pixels into words and holds them in a single-entry valid/ready output slot.
module bnn_bit_packer
   import bnn_pkg::*;
#(
   parameter int PACK_WIDTH = PACK_WIDTH_DEF
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                bit_valid,
   input  logic                                bit_val,
   input  logic                                flush,
   input  logic                                out_ready,
   output logic [PACK_WIDTH-1:0]               out_data,
   output logic [clog2(PACK_WIDTH+1)-1:0]      out_count,
   output logic                                out_valid,
   output logic                                overflow_err,
   output logic                                pending
);

   localparam int CNT_W = clog2(PACK_WIDTH + 1);

   logic [PACK_WIDTH-1:0] pack_q, pack_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [PACK_WIDTH-1:0] out_data_q, out_data_d;
   logic [CNT_W-1:0]      out_count_q, out_count_d;
   logic                  out_valid_q, out_valid_d;
   logic                  overflow_q, overflow_d;
   logic [PACK_WIDTH-1:0] word_s;
   logic [CNT_W-1:0]      cnt_s;
   logic                  emit_s;
   logic                  slot_free_s;

   // Next-state: append the new bit, then emit a full or flushed word into the slot.
   always_comb begin
      pack_d      = pack_q;
      bit_cnt_d   = bit_cnt_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      out_valid_d = out_valid_q;
      overflow_d  = overflow_q;

      if (bit_valid) begin
         word_s = pack_q | (PACK_WIDTH'(bit_val) << bit_cnt_q);
         cnt_s  = bit_cnt_q + CNT_W'(1);
      end else begin
         word_s = pack_q;
         cnt_s  = bit_cnt_q;
      end

      emit_s      = (cnt_s == CNT_W'(PACK_WIDTH)) || (flush && (cnt_s != CNT_W'(0)));
      slot_free_s = !out_valid_q || out_ready;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end

      if (emit_s) begin
         pack_d    = {PACK_WIDTH{1'b0}};
         bit_cnt_d = CNT_W'(0);
         // A word that finds the slot occupied is lost; only the sticky flag records it.
         if (slot_free_s) begin
            out_data_d  = word_s;
            out_count_d = cnt_s;
            out_valid_d = 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end else begin
         pack_d    = word_s;
         bit_cnt_d = cnt_s;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pack_q      <= {PACK_WIDTH{1'b0}};
         bit_cnt_q   <= CNT_W'(0);
         out_data_q  <= {PACK_WIDTH{1'b0}};
         out_count_q <= CNT_W'(0);
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         pack_q      <= pack_d;
         bit_cnt_q   <= bit_cnt_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
         out_valid_q <= out_valid_d;
         overflow_q  <= overflow_d;
      end
   end

   assign out_data     = out_data_q;
   assign out_count    = out_count_q;
   assign out_valid    = out_valid_q;
   assign overflow_err = overflow_q;
   assign pending      = (bit_cnt_q != CNT_W'(0));

endmodule

// File: rtl/bnn_psum_collector.sv
// Accumulates KROWS partial sums per pixel, binarizes against a threshold and packs the bits.
// Optional macro BNN_PSUM_SAT_EN makes the accumulator saturate instead of wrapping.
module bnn_psum_collector
   import bnn_pkg::*;
#(
   parameter int PSUM_WIDTH = PSUM_WIDTH_DEF,
   parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
   parameter int KROWS      = 3,
   parameter int PACK_WIDTH = PACK_WIDTH_DEF
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            en,
   input  logic [PSUM_WIDTH-1:0]           psum_in,
   input  logic                            psum_valid,
   input  logic [ACC_WIDTH-1:0]            thresh_in,
   input  logic                            thresh_load,
   input  logic                            flush,
   output logic [PACK_WIDTH-1:0]           out_data,
   output logic [clog2(PACK_WIDTH+1)-1:0]  out_count,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            busy,
   output logic                            overflow_err
);

   localparam int ROW_W = clog2(KROWS + 1);

   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [ROW_W-1:0]     row_cnt_q, row_cnt_d;
   logic [ACC_WIDTH-1:0] thresh_q, thresh_d;
   logic [ACC_WIDTH-1:0] sum_s;
   logic                 accept_s;
   logic                 last_row_s;
   logic                 bit_valid_s;
   logic                 bit_val_s;
   logic                 flush_go_s;
   logic                 pending_s;
`ifdef BNN_PSUM_SAT_EN
   logic [ACC_WIDTH:0]   sum_wide_s;
`endif

   // Accumulator add, then the saturating or wrapping reduction to ACC_WIDTH.
   always_comb begin
`ifdef BNN_PSUM_SAT_EN
      sum_wide_s = {1'b0, acc_q} + (ACC_WIDTH + 1)'(psum_in);
      if (sum_wide_s[ACC_WIDTH]) begin
         sum_s = {ACC_WIDTH{1'b1}};
      end else begin
         sum_s = sum_wide_s[ACC_WIDTH-1:0];
      end
`else
      sum_s = acc_q + ACC_WIDTH'(psum_in);
`endif
   end

   assign accept_s    = en && psum_valid;
   assign last_row_s  = (row_cnt_q == ROW_W'(KROWS - 1));
   assign bit_valid_s = accept_s && last_row_s;
   assign bit_val_s   = (sum_s >= thresh_q);
   assign flush_go_s  = en && flush;

   // Row accumulation; a flush discards any half-built pixel after the same-cycle psum is used.
   always_comb begin
      acc_d     = acc_q;
      row_cnt_d = row_cnt_q;
      if (flush_go_s) begin
         acc_d     = {ACC_WIDTH{1'b0}};
         row_cnt_d = ROW_W'(0);
      end else if (accept_s) begin
         if (last_row_s) begin
            acc_d     = {ACC_WIDTH{1'b0}};
            row_cnt_d = ROW_W'(0);
         end else begin
            acc_d     = sum_s;
            row_cnt_d = row_cnt_q + ROW_W'(1);
         end
      end else begin
         acc_d     = acc_q;
         row_cnt_d = row_cnt_q;
      end
   end

   // Threshold register write, independent of en.
   always_comb begin
      if (thresh_load) begin
         thresh_d = thresh_in;
      end else begin
         thresh_d = thresh_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_q     <= {ACC_WIDTH{1'b0}};
         row_cnt_q <= ROW_W'(0);
         thresh_q  <= {ACC_WIDTH{1'b0}};
      end else begin
         acc_q     <= acc_d;
         row_cnt_q <= row_cnt_d;
         thresh_q  <= thresh_d;
      end
   end

   bnn_bit_packer #(
      .PACK_WIDTH (PACK_WIDTH)
   ) u_packer (
      .clk          (clk),
      .rst          (rst),
      .bit_valid    (bit_valid_s),
      .bit_val      (bit_val_s),
      .flush        (flush_go_s),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_count    (out_count),
      .out_valid    (out_valid),
      .overflow_err (overflow_err),
      .pending      (pending_s)
   );

   assign busy = (row_cnt_q != ROW_W'(0)) || pending_s || out_valid;

endmodule

// File: tb/tb_bnn_psum_collector.sv
// Scoreboard bench for bnn_psum_collector: expected words are queued when stimulus is driven
// and compared by a monitor at each output transfer; a second instance covers 4-bit accumulation.
module tb_bnn_psum_collector;

   logic       clk = 1'b0;
   logic       rst;
   logic       en, psum_valid, thresh_load, flush, out_ready;
   logic [3:0] psum_in;
   logic [7:0] thresh_in;
   logic [7:0] out_data;
   logic [3:0] out_count;
   logic       out_valid, busy, overflow_err;

   logic       s_en, s_psum_valid, s_thresh_load, s_flush, s_out_ready;
   logic [3:0] s_psum_in, s_thresh_in;
   logic [7:0] s_out_data;
   logic [3:0] s_out_count;
   logic       s_out_valid, s_busy, s_overflow_err;

   typedef struct packed {
      logic [7:0] data;
      logic [3:0] count;
   } word_t;

   word_t exp_q[$];
   word_t mon_exp;
   int    total = 0;
   int    bad   = 0;

   always #5 clk = ~clk;

   bnn_psum_collector dut (
      .clk(clk), .rst(rst), .en(en), .psum_in(psum_in), .psum_valid(psum_valid),
      .thresh_in(thresh_in), .thresh_load(thresh_load), .flush(flush),
      .out_data(out_data), .out_count(out_count), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .overflow_err(overflow_err)
   );

   bnn_psum_collector #(.PSUM_WIDTH(4), .ACC_WIDTH(4), .KROWS(3), .PACK_WIDTH(8)) u_sat (
      .clk(clk), .rst(rst), .en(s_en), .psum_in(s_psum_in), .psum_valid(s_psum_valid),
      .thresh_in(s_thresh_in), .thresh_load(s_thresh_load), .flush(s_flush),
      .out_data(s_out_data), .out_count(s_out_count), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .busy(s_busy), .overflow_err(s_overflow_err)
   );

   // Monitor: every completed transfer is checked against the head of the scoreboard.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_word got data=%h count=%0d, no word expected", out_data, out_count);
         end else begin
            mon_exp = exp_q.pop_front();
            if (out_data !== mon_exp.data || out_count !== mon_exp.count) begin
               bad++;
               $display("FAIL word got data=%h count=%0d want data=%h count=%0d",
                        out_data, out_count, mon_exp.data, mon_exp.count);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [3:0] v, input logic e);
      psum_in = v; psum_valid = 1'b1; en = e;
      step();
      psum_valid = 1'b0; en = 1'b1;
   endtask

   // With threshold 5: 2+2+1 = 5 gives bit 1, 1+1+1 = 3 gives bit 0.
   task automatic pixel(input logic b);
      if (b) begin feed(4'd2, 1'b1); feed(4'd2, 1'b1); feed(4'd1, 1'b1); end
      else   begin feed(4'd1, 1'b1); feed(4'd1, 1'b1); feed(4'd1, 1'b1); end
   endtask

   task automatic do_flush();
      en = 1'b1; flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   task automatic load_thresh(input logic [7:0] t);
      thresh_in = t; thresh_load = 1'b1;
      step();
      thresh_load = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) step();
      total += 5;
      if (out_valid !== 1'b0)    begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      if (out_data !== 8'h00)    begin bad++; $display("FAIL reset_data got=%h want=00", out_data); end
      if (out_count !== 4'd0)    begin bad++; $display("FAIL reset_count got=%0d want=0", out_count); end
      if (busy !== 1'b0)         begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      if (overflow_err !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow_err); end
      rst = 1'b1;
      step();
   endtask

   task automatic test_threshold();
      out_ready = 1'b1;
      load_thresh(8'd5);
      pixel(1'b1);
      pixel(1'b0);
      feed(4'd3, 1'b1);
      feed(4'd1, 1'b0);
      feed(4'd1, 1'b1);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL thr_ignored_psum got valid=%b want=0", out_valid); end
      feed(4'd1, 1'b1);
      exp_q.push_back('{data: 8'h05, count: 4'd3});
      do_flush();
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL thr_flush_valid got=%b want=1", out_valid); end
      step();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL thr_busy got=%b want=0", busy); end
   endtask

   task automatic test_packing();
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) pixel((i % 2) == 0);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL pack_early_valid got=%b want=0", out_valid); end
      exp_q.push_back('{data: 8'h55, count: 4'd8});
      pixel(1'b0);
      total += 2;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL pack_valid_rise got=%b want=1", out_valid); end
      step();
      if (out_valid !== 1'b0) begin bad++; $display("FAIL pack_valid_one_cycle got=%b want=0", out_valid); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) pixel(1'b1);
      exp_q.push_back('{data: 8'hFF, count: 4'd8});
      total++;
      if (overflow_err !== 1'b0) begin bad++; $display("FAIL bp_ovf_early got=%b want=0", overflow_err); end
      for (int i = 0; i < 8; i++) pixel(1'b0);
      total += 4;
      if (out_valid !== 1'b1)    begin bad++; $display("FAIL bp_held_valid got=%b want=1", out_valid); end
      if (out_data !== 8'hFF)    begin bad++; $display("FAIL bp_held_data got=%h want=ff", out_data); end
      if (out_count !== 4'd8)    begin bad++; $display("FAIL bp_held_count got=%0d want=8", out_count); end
      if (overflow_err !== 1'b1) begin bad++; $display("FAIL bp_ovf got=%b want=1", overflow_err); end
      out_ready = 1'b1;
      step();
      total += 2;
      if (out_valid !== 1'b0)    begin bad++; $display("FAIL bp_drain got=%b want=0", out_valid); end
      if (overflow_err !== 1'b1) begin bad++; $display("FAIL bp_ovf_sticky got=%b want=1", overflow_err); end
   endtask

   task automatic test_flush();
      out_ready = 1'b1;
      pixel(1'b1); pixel(1'b1); pixel(1'b0);
      feed(4'd2, 1'b1); feed(4'd2, 1'b1);
      exp_q.push_back('{data: 8'h03, count: 4'd3});
      do_flush();
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_valid got=%b want=1", out_valid); end
      step();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", busy); end
      do_flush();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_empty got=%b want=0", out_valid); end
      // Final psum of a pixel arriving together with flush is packed before the word goes out.
      pixel(1'b1);
      feed(4'd2, 1'b1); feed(4'd2, 1'b1);
      exp_q.push_back('{data: 8'h03, count: 4'd2});
      psum_in = 4'd1; psum_valid = 1'b1; flush = 1'b1;
      step();
      psum_valid = 1'b0; flush = 1'b0;
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_same_cycle got=%b want=1", out_valid); end
      step();
   endtask

   task automatic test_saturation();
      logic [7:0] want;
`ifdef BNN_PSUM_SAT_EN
      want = 8'h01;
`else
      want = 8'h00;
`endif
      s_out_ready = 1'b0;
      s_thresh_in = 4'd14; s_thresh_load = 1'b1;
      step();
      s_thresh_load = 1'b0;
      s_en = 1'b1; s_psum_in = 4'd15; s_psum_valid = 1'b1;
      repeat (3) step();
      s_psum_valid = 1'b0; s_flush = 1'b1;
      step();
      s_flush = 1'b0;
      total += 3;
      if (s_out_valid !== 1'b1) begin bad++; $display("FAIL sat_valid got=%b want=1", s_out_valid); end
      if (s_out_data !== want)  begin bad++; $display("FAIL sat_bit got=%h want=%h", s_out_data, want); end
      if (s_out_count !== 4'd1) begin bad++; $display("FAIL sat_count got=%0d want=1", s_out_count); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) pixel(1'b1);
      pixel(1'b1);
      feed(4'd2, 1'b1);
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre_valid got=%b want=1", out_valid); end
      rst = 1'b0; en = 1'b1; flush = 1'b1; thresh_in = 8'd200; thresh_load = 1'b1;
      step();
      rst = 1'b1; flush = 1'b0; thresh_load = 1'b0;
      total += 5;
      if (out_valid !== 1'b0)    begin bad++; $display("FAIL rmid_valid got=%b want=0", out_valid); end
      if (out_data !== 8'h00)    begin bad++; $display("FAIL rmid_data got=%h want=00", out_data); end
      if (out_count !== 4'd0)    begin bad++; $display("FAIL rmid_count got=%0d want=0", out_count); end
      if (busy !== 1'b0)         begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
      if (overflow_err !== 1'b0) begin bad++; $display("FAIL rmid_ovf got=%b want=0", overflow_err); end
      out_ready = 1'b1;
      feed(4'd0, 1'b1); feed(4'd0, 1'b1); feed(4'd0, 1'b1);
      exp_q.push_back('{data: 8'h01, count: 4'd1});
      do_flush();
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL rmid_zero_pixel got=%b want=1", out_valid); end
      step();
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; psum_valid = 1'b0; psum_in = 4'd0;
      thresh_in = 8'd0; thresh_load = 1'b0; flush = 1'b0; out_ready = 1'b0;
      s_en = 1'b0; s_psum_valid = 1'b0; s_psum_in = 4'd0; s_thresh_in = 4'd0;
      s_thresh_load = 1'b0; s_flush = 1'b0; s_out_ready = 1'b0;
      test_reset();
      test_threshold();
      test_packing();
      test_backpressure();
      test_flush();
      test_saturation();
      test_reset_mid();
      repeat (3) step();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain got=%0d pending want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bnn_psum_collector.md
BNN_PSUM_COLLECTOR -- requirements
Module: bnn_psum_collector

Interface
REQ-001 The block SHALL have parameter PSUM_WIDTH, default 4, giving the width of the incoming PE-column partial sum.
REQ-002 The block SHALL have parameter ACC_WIDTH, default 8, giving the width of the accumulator and threshold.
REQ-003 The block SHALL have parameter KROWS, default 3, giving the number of partial sums accumulated per output pixel.
REQ-004 The block SHALL have parameter PACK_WIDTH, default 8, giving the number of activation bits per output word.
REQ-005 The block SHALL have these ports: clk  input  1  clock; rst  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have these ports: en  input  1  global advance enable; psum_in  input  PSUM_WIDTH  partial sum from the PE column; psum_valid  input  1  psum_in qualifier.
REQ-007 The block SHALL have these ports: thresh_in  input  ACC_WIDTH  binarization threshold; thresh_load  input  1  threshold write strobe; flush  input  1  emit the partial word.
REQ-008 The block SHALL have these ports: out_data  output  PACK_WIDTH  packed activations; out_count  output  clog2(PACK_WIDTH+1)  number of valid bits; out_valid  output  1; out_ready  input  1.
REQ-009 The block SHALL have these ports: busy  output  1  work in flight; overflow_err  output  1  sticky word-drop flag.

Function
REQ-010 A psum SHALL be accepted only in a cycle with en=1 and psum_valid=1; sum = acc + psum_in, zero-extended to ACC_WIDTH.
REQ-011 The block SHALL count accepted psums in row_cnt; when row_cnt<KROWS-1, acc<=sum and row_cnt increments.
REQ-012 When row_cnt==KROWS-1, bit=(sum>=thresh_reg) unsigned, acc<=0, row_cnt<=0, and pack_reg[bit_cnt]<=bit (pixel 0 lands in bit 0); bit_cnt then increments.
REQ-013 When the bit completes a word (bit_cnt==PACK_WIDTH-1), the block SHALL move the word into the output slot with out_count=PACK_WIDTH, clear pack_reg and set bit_cnt=0; out_valid SHALL rise the cycle after the final psum is accepted.
REQ-014 The output slot SHALL count as free if out_valid=0 or if out_valid&&out_ready in that same cycle; if the slot is not free, the new word SHALL be dropped and overflow_err set to 1.
REQ-015 out_data and out_count SHALL stay stable while out_valid&&!out_ready, and out_valid SHALL clear after the transfer cycle unless a new word loads.
REQ-016 The output handshake and thresh_load SHALL operate regardless of en.
REQ-017 thresh_load=1 SHALL write thresh_reg<=thresh_in; the new value applies from the next cycle.
REQ-018 On en&&flush, the psum arriving in the same cycle SHALL be processed first; any resulting partial word (bit_cnt>0) SHALL then be emitted zero-padded with out_count=bit_cnt under the slot rules of REQ-014.
REQ-019 On flush, an incomplete pixel (row_cnt!=0) SHALL be discarded: acc<=0 and row_cnt<=0.
REQ-020 A flush with no bits pending SHALL emit no word.
REQ-021 busy SHALL equal (row_cnt!=0)||(bit_cnt!=0)||out_valid.
REQ-022 overflow_err SHALL clear only on reset.

Reset
REQ-023 rst=0 at a clock edge SHALL clear the following, including mid-word or mid-handshake, with any pending word lost: acc, row_cnt, bit_cnt, pack_reg, out_data, out_count, out_valid, overflow_err, and thresh_reg.
REQ-024 Reset SHALL take priority over en, flush and thresh_load.

Configuration
REQ-025 With macro BNN_PSUM_SAT_EN defined, acc+psum_in SHALL saturate at 2^ACC_WIDTH-1.
REQ-026 Without BNN_PSUM_SAT_EN, acc+psum_in SHALL wrap modulo 2^ACC_WIDTH.

Structure
REQ-027 Shared package bnn_pkg SHALL hold the default PSUM_WIDTH, ACC_WIDTH and PACK_WIDTH constants and the clog2 function used for counter widths.
REQ-028 The pack register, bit_cnt, output slot and handshake SHALL be a sub-module bnn_bit_packer; the accumulator, row_cnt and threshold compare stay in the top level.

Verification
REQ-029 Threshold scenario: KROWS=3, thresh=5, psums 2,2,1 -> bit 1; psums 1,1,1 -> bit 0; psums 3,1,1 with en=0 on the middle psum, which is ignored -> pixel completes only on a 3rd accepted psum.
REQ-030 Packing scenario: 8 pixels giving bits 1,0,1,0,1,0,1,0 with out_ready=1 -> out_data=8'h55, out_count=8, out_valid high exactly one cycle, starting the cycle after the last psum.
REQ-031 Backpressure scenario: out_ready=0 while two full words complete -> first word held stable, overflow_err=1, second word dropped; out_ready=1 -> first word transfers, then out_valid=0.
REQ-032 Flush scenario: bits 1,1,0 plus 2 psums of a 4th pixel, then flush -> out_data=8'h03, out_count=3, busy=0 after the handshake; a second flush produces no word.
REQ-033 Saturation scenario: ACC_WIDTH=4, PSUM_WIDTH=4, thresh=14, psums 15,15,15 -> acc 15, bit 1 with BNN_PSUM_SAT_EN; acc 13 (45 mod 16), bit 0 without it.
REQ-034 Reset scenario: rst=0 mid-word with out_valid=1 -> next cycle all outputs 0, thresh_reg 0, and a later all-zero pixel yields bit 1.
